// File: rtl/bus_unpack_v1_0_if.sv
// Handshake bundle for bus_unpack_v1_0: one wide input port and one narrow output port.
// The master modport is the side that produces words and consumes beats; slave is the converter.
interface bus_unpack_v1_0_if #(
    parameter int in_width  = 32,
    parameter int out_width = 8
);
    logic [in_width-1:0]  in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [out_width-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/bus_unpack_v1_0.sv
// Width-down converter: one in_width word in, in_width/out_width beats of out_width out.
// Define BUS_UNPACK_MSB_FIRST_EN to emit the most significant slice first (default: LSB first).
module bus_unpack_v1_0 #(
    parameter int in_width  = 32,
    parameter int out_width = 8
) (
    input  logic                clock,
    input  logic                reset,
    bus_unpack_v1_0_if.slave    bus
);
    localparam int RATIO = in_width / out_width;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((in_width % out_width) != 0) begin : g_bad_width
        $error("bus_unpack_v1_0: in_width must be a multiple of out_width");
    end

    logic [in_width-1:0] hold;
    logic [CW-1:0]       beat;
    logic                full;
    logic                in_fire;
    logic                out_fire;
    logic                last_beat;

    // A transfer happens on a port exactly when valid and ready are both high at the
    // rising edge; valid never waits on ready, and in_ready may depend on out_ready.
    assign last_beat     = (beat == CW'(RATIO - 1));
    assign bus.out_valid = full;
    assign bus.out_last  = full & last_beat;
    assign bus.in_ready  = !full | (bus.out_ready & bus.out_last);
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign out_fire      = full & bus.out_ready;

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (beat == CW'(k)) begin
`ifdef BUS_UNPACK_MSB_FIRST_EN
                bus.out_data = hold[in_width-1-k*out_width -: out_width];
`else
                bus.out_data = hold[k*out_width +: out_width];
`endif
            end
        end
    end

    // A new word loading on the last beat takes priority, so words stream without a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold <= '0;
            beat <= '0;
            full <= 1'b0;
        end else if (in_fire) begin
            hold <= bus.in_data;
            beat <= '0;
            full <= 1'b1;
        end else if (out_fire) begin
            if (last_beat) begin
                beat <= '0;
                full <= 1'b0;
            end else begin
                beat <= beat + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_bus_unpack_v1_0.sv
// Self-checking bench for bus_unpack_v1_0: directed test-plan steps plus random traffic
// against a beat-queue reference model; also exercises an 8->8 (ratio 1) instance.
module tb_bus_unpack_v1_0;
    logic clock;
    logic reset;

    bus_unpack_v1_0_if #(.in_width(32), .out_width(8)) bus ();
    bus_unpack_v1_0_if #(.in_width(8),  .out_width(8)) bus2 ();

    bus_unpack_v1_0 #(.in_width(32), .out_width(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    bus_unpack_v1_0 #(.in_width(8), .out_width(8)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard: beats still owed by the converter, oldest first
    logic [7:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Split a 32-bit word into the byte order the consumer should see.
    task automatic push_word(input logic [31:0] w);
        logic [31:0] t;
        for (int k = 0; k < 4; k++) begin
`ifdef BUS_UNPACK_MSB_FIRST_EN
            t = w >> ((3 - k) * 8);
`else
            t = w >> (k * 8);
`endif
            exp_q.push_back(t[7:0]);
        end
    endtask

    // driver: called at a negedge, drives one cycle, checks, advances the model
    task automatic step(input logic iv, input logic [31:0] id, input logic ordy);
        logic exp_valid, exp_last, exp_irdy, in_fire, out_fire;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        exp_valid = (exp_q.size() != 0);
        exp_last  = (exp_q.size() == 1);
        exp_irdy  = (exp_q.size() == 0) || (ordy && exp_q.size() == 1);
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("out_last",  32'(bus.out_last),  32'(exp_last));
        check("in_ready",  32'(bus.in_ready),  32'(exp_irdy));
        if (exp_valid) check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
        in_fire  = iv && exp_irdy;
        out_fire = exp_valid && ordy;
        @(posedge clock);
        if (out_fire) void'(exp_q.pop_front());
        if (in_fire) push_word(id);
        @(negedge clock);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_last"},  32'(bus.out_last),  32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready),  32'd1);
        check({tag, "_data"},  32'(bus.out_data),  32'd0);
    endtask

    task automatic do_reset(input int cycles);
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus2.in_valid = 1'b0;
        repeat (cycles) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.out_ready = 1'b0;

        // reset then idle
        do_reset(2);
        reset_checks("rst");
        check("rst2_valid", 32'(bus2.out_valid), 32'd0);
        check("rst2_ready", 32'(bus2.in_ready), 32'd1);
        step(1'b0, 32'h0, 1'b1);

        // single word, one beat per cycle
        step(1'b1, 32'hA1B2C3D4, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1);

        // back-to-back words with in_valid held high
        step(1'b1, 32'h11223344, 1'b1);
        repeat (4) step(1'b1, 32'h55667788, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1);

        // backpressure during beat 1; an offered word must not be taken
        step(1'b1, 32'hA1B2C3D4, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'hDEADBEEF, 1'b0);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // reset mid-word after two beats
        step(1'b1, 32'hA1B2C3D4, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b1);
        do_reset(1);
        reset_checks("midrst");
        step(1'b1, 32'hDEADBEEF, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
        end
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // ratio-1 instance: one-deep registered pipeline
        bus2.in_valid  = 1'b1;
        bus2.in_data   = 8'h5A;
        bus2.out_ready = 1'b0;
        #1;
        check("r1_ready_empty", 32'(bus2.in_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus2.in_valid = 1'b0;
        #1;
        check("r1_valid", 32'(bus2.out_valid), 32'd1);
        check("r1_data",  32'(bus2.out_data),  32'h5A);
        check("r1_last",  32'(bus2.out_last),  32'd1);
        check("r1_ready_stall", 32'(bus2.in_ready), 32'd0);
        bus2.in_valid  = 1'b1;
        bus2.in_data   = 8'hC3;
        bus2.out_ready = 1'b1;
        #1;
        check("r1_ready_drain", 32'(bus2.in_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus2.in_valid = 1'b0;
        #1;
        check("r1_valid2", 32'(bus2.out_valid), 32'd1);
        check("r1_data2",  32'(bus2.out_data),  32'hC3);
        @(posedge clock);
        @(negedge clock);
        check("r1_idle", 32'(bus2.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
